// File: rtl/inst_fetch.sv
// Byte-queue instruction fetch: 1-byte instructions are valid one cycle after their ack; holds inst while inst_ready=0.
// Optional FETCH_PREFETCH_EN keeps requesting bytes up to QDEPTH while an instruction waits; otherwise fetch stalls.
module inst_fetch #(
   parameter int          QDEPTH   = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [7:0]    q [QDEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW-1:0] pop_len;
   logic [15:0]   fetch_addr;
   logic [15:0]   fetch_addr_next;
   logic [15:0]   pc;
   logic [7:0]    head;
   logic [7:0]    second;
   logic          two_byte;
   logic          push;
   logic          pop;
   logic          issue;

   assign head     = q[rd_ptr];
   assign second   = q[rd_ptr + AW'(1)];
   assign two_byte = head[7];

   assign inst_valid = ((count >= CW'(1)) && !two_byte) || ((count >= CW'(2)) && two_byte);
   assign inst       = !inst_valid ? 16'h0000 : (two_byte ? {head, second} : {head, 8'h00});
   assign inst_pc    = pc;
   assign mem_req    = (state == REQ) || (state == DRAIN);

   // Redirect outranks both the consume and the push of a same-cycle ack.
   assign pop     = inst_valid && inst_ready && !redirect;
   assign push    = (state == REQ) && mem_ack && !redirect;
   assign pop_len = !pop ? CW'(0) : (two_byte ? CW'(2) : CW'(1));

   assign rd_ptr_next     = rd_ptr + AW'(pop_len);
   assign count_next      = redirect ? CW'(0) : (count + CW'(push) - pop_len);
   assign fetch_addr_next = redirect ? redirect_pc : (push ? fetch_addr + 16'd1 : fetch_addr);

`ifdef FETCH_PREFETCH_EN
   assign issue = 1'b1;
`else
   logic [7:0] head_next;

   // With a single byte left after this edge, it is the pushed byte when a push lands on the new head.
   assign head_next = (push && (wr_ptr == rd_ptr_next)) ? mem_rdata : q[rd_ptr_next];
   assign issue     = (count_next == CW'(0)) || ((count_next == CW'(1)) && head_next[7]);
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!redirect && (count_next < DEPTH) && issue)
               state_next = REQ;
         end
         REQ: begin
            if (redirect)
               state_next = mem_ack ? IDLE : DRAIN;
            else if (mem_ack)
               state_next = ((count_next < DEPTH) && issue) ? REQ : IDLE;
         end
         DRAIN: begin
            if (mem_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         fetch_addr <= RESET_PC;
         mem_addr   <= RESET_PC;
         pc         <= RESET_PC;
      end else begin
         state      <= state_next;
         count      <= count_next;
         fetch_addr <= fetch_addr_next;
         // A draining request keeps presenting the address it was issued with.
         if (state_next != DRAIN)
            mem_addr <= fetch_addr_next;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= redirect_pc;
         end else begin
            rd_ptr <= rd_ptr_next;
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               pc <= pc + 16'(pop_len);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++)
            q[i] <= 8'h00;
      end else if (push) begin
         q[wr_ptr] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stream assembly, slow memory, stall, redirect/drain, reset and address wrap.
`timescale 1ns/1ps
module tb_inst_fetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (RESET_PC = 0000)
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

   // wrap instance (RESET_PC = FFFF)
   logic        rst_w_n;
   logic        w_req;
   logic [15:0] w_addr;
   logic        w_ack;
   logic [7:0]  w_rdata;
   logic [15:0] w_inst;
   logic [15:0] w_pc;
   logic        w_valid;
   logic        w_ready;
   logic        w_redirect;
   logic [15:0] w_redirect_pc;

   logic [7:0]  mem [0:65535];
   logic        manual;
   logic        man_ack;
   logic [7:0]  man_rdata;
   logic        auto_ack;
   logic [7:0]  auto_rdata;
   int          ack_delay;
   int          wait_cnt;
   logic [15:0] ack_log [$];

   int checks = 0;
   int errors = 0;

   assign mem_ack   = manual ? man_ack : auto_ack;
   assign mem_rdata = manual ? man_rdata : auto_rdata;

   assign w_ack   = w_req;
   assign w_rdata = (w_addr == 16'hFFFF) ? 8'h90 :
                    (w_addr == 16'h0000) ? 8'h42 :
                    (w_addr == 16'h0001) ? 8'h05 : 8'h00;

   inst_fetch #(.QDEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   inst_fetch #(.QDEPTH(4), .RESET_PC(16'hFFFF)) dut_w (
      .clk(clk), .rst_n(rst_w_n),
      .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
      .inst(w_inst), .inst_pc(w_pc), .inst_valid(w_valid), .inst_ready(w_ready),
      .redirect(w_redirect), .redirect_pc(w_redirect_pc)
   );

   // Memory responder: acks after ack_delay idle cycles of a request, driven on the falling edge.
   initial begin
      auto_ack   = 1'b0;
      auto_rdata = 8'h00;
      wait_cnt   = 0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req) begin
            if (wait_cnt >= ack_delay) begin
               auto_ack   = 1'b1;
               auto_rdata = mem[mem_addr];
               ack_log.push_back(mem_addr);
               wait_cnt   = 0;
            end else begin
               auto_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            auto_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Wait (bounded) for a valid instruction, check it, then consume it with a one-cycle inst_ready pulse.
   task automatic take(input string tag, input logic [15:0] exp_inst, input logic [15:0] exp_pc);
      int n = 0;
      while (!inst_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 16'(inst_valid), 16'h0001);
      check({tag, "_inst"}, inst, exp_inst);
      check({tag, "_pc"}, inst_pc, exp_pc);
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   initial begin
      int nb;
      rst_n = 1'b0; rst_w_n = 1'b0;
      inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 16'h0000;
      manual = 1'b0; man_ack = 1'b0; man_rdata = 8'h00; ack_delay = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h88; mem[16'h0002] = 8'h05; mem[16'h0003] = 8'h00;
      for (int i = 0; i < 16; i++) mem[16'h0200 + i] = 8'(8'h11 + i);
      mem[16'h0300] = 8'hC0; mem[16'h0301] = 8'hFE;

      repeat (3) tick();
      check("rst_req", 16'(mem_req), 16'h0000);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_inst", inst, 16'h0000);
      check("rst_pc", inst_pc, 16'h0000);
      check("rst_valid", 16'(inst_valid), 16'h0000);
      check("rstw_addr", w_addr, 16'hFFFF);
      check("rstw_pc", w_pc, 16'hFFFF);
      check("rstw_req", 16'(w_req), 16'h0000);

      // stream 01 / 88 05 / 00 with zero-wait memory
      rst_n = 1'b1;
      tick();
      check("a_e1_req", 16'(mem_req), 16'h0001);
      check("a_e1_addr", mem_addr, 16'h0000);
      check("a_e1_valid", 16'(inst_valid), 16'h0000);
      tick();
      check("a_e2_valid", 16'(inst_valid), 16'h0001);
      take("a0", 16'h0100, 16'h0000);
      take("a1", 16'h8805, 16'h0001);
      take("a2", 16'h0000, 16'h0003);
      check("a_log_n", 16'(ack_log.size() >= 4), 16'h0001);
      for (int i = 0; i < 4; i++)
         check("a_log_addr", (ack_log.size() > i) ? ack_log[i] : 16'hxxxx, 16'(i));

      // stall with inst_ready=0
      redirect = 1'b1; redirect_pc = 16'h0200;
      tick();
      redirect = 1'b0;
      check("b_flush_valid", 16'(inst_valid), 16'h0000);
      check("b_flush_pc", inst_pc, 16'h0200);
      repeat (15) tick();
      nb = 0;
      foreach (ack_log[i]) if (ack_log[i] >= 16'h0200 && ack_log[i] < 16'h0210) nb++;
`ifdef FETCH_PREFETCH_EN
      check("b_fetched", 16'(nb), 16'h0004);
`else
      check("b_fetched", 16'(nb), 16'h0001);
`endif
      check("b_req", 16'(mem_req), 16'h0000);
      check("b_valid", 16'(inst_valid), 16'h0001);
      check("b_inst", inst, 16'h1100);
      check("b_pc", inst_pc, 16'h0200);
      repeat (3) tick();
      check("b_hold_inst", inst, 16'h1100);
      check("b_hold_valid", 16'(inst_valid), 16'h0001);

      // three idle cycles per byte
      ack_delay = 3;
      redirect = 1'b1; redirect_pc = 16'h0300;
      tick();
      redirect = 1'b0;
      check("c_r_req", 16'(mem_req), 16'h0000);
      check("c_r_valid", 16'(inst_valid), 16'h0000);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("c_req", 16'(mem_req), 16'h0001);
         check("c_addr", mem_addr, (k <= 4) ? 16'h0300 : 16'h0301);
         check("c_valid", 16'(inst_valid), 16'h0000);
      end
      tick();
      check("c_done_valid", 16'(inst_valid), 16'h0001);
      check("c_inst", inst, 16'hC0FE);
      check("c_pc", inst_pc, 16'h0300);

      // redirect during an outstanding request, then again while draining
      ack_delay = 0;
      repeat (10) tick();
      check("d_idle", 16'(mem_req), 16'h0000);
      manual = 1'b1;
      redirect = 1'b1; redirect_pc = 16'h0002;
      tick();
      redirect = 1'b0;
      check("d_r_req", 16'(mem_req), 16'h0000);
      tick();
      check("d_req", 16'(mem_req), 16'h0001);
      check("d_addr", mem_addr, 16'h0002);
      redirect = 1'b1; redirect_pc = 16'h0777;
      tick();
      check("d_drain_req", 16'(mem_req), 16'h0001);
      check("d_drain_addr", mem_addr, 16'h0002);
      check("d_drain_valid", 16'(inst_valid), 16'h0000);
      check("d_drain_pc", inst_pc, 16'h0777);
      redirect_pc = 16'h1234;
      tick();
      redirect = 1'b0;
      check("d_drain2_addr", mem_addr, 16'h0002);
      check("d_drain2_pc", inst_pc, 16'h1234);
      tick();
      check("d_drain3_req", 16'(mem_req), 16'h0001);
      man_ack = 1'b1; man_rdata = 8'hAA;
      tick();
      man_ack = 1'b0;
      check("d_post_req", 16'(mem_req), 16'h0000);
      check("d_post_valid", 16'(inst_valid), 16'h0000);
      tick();
      check("d_new_req", 16'(mem_req), 16'h0001);
      check("d_new_addr", mem_addr, 16'h1234);
      check("d_new_valid", 16'(inst_valid), 16'h0000);
      man_ack = 1'b1; man_rdata = 8'h7E;
      tick();
      man_ack = 1'b0;
      check("d_inst", inst, 16'h7E00);
      check("d_pc", inst_pc, 16'h1234);

      // redirect, consume and ack all in one cycle
      redirect = 1'b1; redirect_pc = 16'h0400; inst_ready = 1'b1;
      man_ack = 1'b1; man_rdata = 8'h33;
      tick();
      redirect = 1'b0; inst_ready = 1'b0; man_ack = 1'b0;
      check("e_valid", 16'(inst_valid), 16'h0000);
      check("e_pc", inst_pc, 16'h0400);
      check("e_req", 16'(mem_req), 16'h0000);
      tick();
      check("e_next_addr", mem_addr, 16'h0400);
      check("e_next_valid", 16'(inst_valid), 16'h0000);
      man_ack = 1'b1; man_rdata = 8'h44;
      tick();
      man_ack = 1'b0;
      check("e_inst", inst, 16'h4400);
      check("e_inst_pc", inst_pc, 16'h0400);

      // reset during an outstanding request
      redirect = 1'b1; redirect_pc = 16'h0500;
      tick();
      redirect = 1'b0;
      tick();
      check("r_req_before", 16'(mem_req), 16'h0001);
      #2 rst_n = 1'b0;
      #1 check("r_req_async", 16'(mem_req), 16'h0000);
      man_ack = 1'b1; man_rdata = 8'h55;
      tick();
      tick();
      check("r_req", 16'(mem_req), 16'h0000);
      check("r_valid", 16'(inst_valid), 16'h0000);
      check("r_pc", inst_pc, 16'h0000);
      check("r_addr", mem_addr, 16'h0000);
      man_ack = 1'b0;
      rst_n = 1'b1;

      // instruction split across the FFFF -> 0000 wrap
      rst_w_n = 1'b1;
      tick();
      check("f_e1_req", 16'(w_req), 16'h0001);
      check("f_e1_addr", w_addr, 16'hFFFF);
      tick();
      check("f_e2_valid", 16'(w_valid), 16'h0000);
      check("f_e2_addr", w_addr, 16'h0000);
      tick();
      check("f_valid", 16'(w_valid), 16'h0001);
      check("f_inst", w_inst, 16'h9042);
      check("f_pc", w_pc, 16'hFFFF);
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
      check("f_next_pc", w_pc, 16'h0001);
      tick();
      check("f_next_valid", 16'(w_valid), 16'h0001);
      check("f_next_inst", w_inst, 16'h0500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the 16-bit CPU. It reads instruction bytes from the byte-wide program memory over a req/ack handshake and buffers them in a small byte queue. It assembles each 1- or 2-byte instruction into the 16-bit word the decoder consumes and presents it with its address on a valid/ready handshake. It sits between program memory and the decode/execute stage, and flushes and restarts on branch, call, return or trap redirects.

## Interface
- QDEPTH, 4, byte-queue depth; power of two, minimum 2
- RESET_PC, 16'h0000, fetch address after reset
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- mem_req  out  1  byte read request; registered
- mem_addr  out  16  byte address; stable while mem_req=1
- mem_ack  in  1  completes the request; mem_rdata is valid this cycle
- mem_rdata  in  8  read byte
- inst  out  16  assembled instruction; 16'h0000 when inst_valid=0
- inst_pc  out  16  address of the first byte of inst
- inst_valid  out  1  inst is complete
- inst_ready  in  1  execute consumes inst this cycle
- redirect  in  1  flush and restart fetch
- redirect_pc  in  16  new fetch address

## Operation
- Byte order:
  - first byte → inst[15:8].
  - If inst[15]=0, the instruction is 1 byte, inst[7:0]=8'h00, and the consume pops 1 byte.
  - If inst[15]=1, the second byte → inst[7:0] and the consume pops 2 bytes.
- inst_valid=1 when (count≥1 and head[7]=0) or (count≥2 and head[7]=1).
  - inst and inst_valid are decoded from queue registers only; there is no combinational path from mem_ack or mem_rdata.
- Consume: inst_valid & inst_ready at an edge pops 1 or 2 bytes; inst_pc advances by 1 or 2.
- FSM states:
  - IDLE: mem_req=0. Goes to REQ when count_next<QDEPTH and the issue condition (see Configuration) holds.
  - REQ: mem_req=1, mem_addr=fetch_addr. On mem_ack: push mem_rdata, fetch_addr+1, then stay in REQ if count_next<QDEPTH and the issue condition holds, else go to IDLE.
  - DRAIN: mem_req=1 with the old address held. On mem_ack the byte is discarded and the FSM goes to IDLE.
- Redirect (priority over consume and over push):
  - queue count → 0; fetch_addr and inst_pc ← redirect_pc.
  - IDLE → IDLE.
  - REQ with no ack → DRAIN.
  - REQ with ack in the same cycle → the byte is discarded, then IDLE.
  - DRAIN → DRAIN.
  - A second redirect while in DRAIN updates the addresses again.
- Simultaneous push and pop in one cycle are legal; count_next = count + push − pop.
- mem_ack while mem_req=0 is ignored.
- Address arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000. This applies to both fetch_addr and inst_pc.
- An instruction split across the wrap (first byte at FFFF) takes its second byte from 0000.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst=16'h0000, inst_pc=RESET_PC, inst_valid=0, state IDLE, queue empty.
- Reset asserted mid-request drops mem_req asynchronously; any later ack is ignored.
- mem_req rises at the first edge after rst_n deasserts.
- Zero-wait memory (ack in the request cycle) gives 1 byte per clock.
- A 1-byte instruction is valid 1 cycle after its ack edge.
- First instruction after reset: 1-byte → inst_valid at edge 2; 2-byte → at edge 3.
- Redirect: inst_valid=0 from the next edge.
  - The first new request starts at the next edge from IDLE, or one edge after the drain ack.
- inst_valid, once high, stays high with a stable inst until it is consumed or redirected.

## Configuration
- FETCH_PREFETCH_EN defined: the issue condition is always true, so the queue keeps filling up to QDEPTH while an instruction is waiting.
- FETCH_PREFETCH_EN undefined: the issue condition is that the queue cannot yet form an instruction, i.e. count_next=0, or count_next=1 with head[7]=1.
  - Fetch therefore stalls while an instruction is held, and the queue never holds more than 2 bytes.
  - Functional results are identical in both modes; only throughput differs.

## Test plan
- Reset with zero-wait memory holding 0x01,0x88,0x05,0x00 at 0000 and inst_ready=1 → inst 16'h0100 (pc 0000), then 16'h8805 (pc 0001), then 16'h0000 (pc 0003); mem_addr steps 0000,0001,0002,0003.
- mem_ack delayed 3 cycles per byte → mem_req stays high with mem_addr stable until ack; the 2-byte inst 16'hC0FE appears only after both acks.
- inst_ready=0 with FETCH_PREFETCH_EN defined → exactly QDEPTH=4 bytes are fetched, then mem_req=0. With the macro undefined → fetching stops after the first complete instruction.
- redirect=1, redirect_pc=16'h1234 while a request to 0002 is outstanding → state DRAIN; the ack data 0xAA is discarded; the next request is to 1234; inst_pc=1234.
- redirect in the same cycle as inst_ready and mem_ack → no consume, byte discarded, inst_valid=0 next cycle.
- RESET_PC=16'hFFFF with memory FFFF=0x90, 0000=0x42 → inst 16'h9042, inst_pc FFFF; the next inst_pc is 0001.
